// File: rtl/taxi_mac_pause_ctrl_rx_mc.sv
// Receive-side MAC control pause handler: LFC/PFC decode, per-channel
// pause timers, request/ack state machines and ack watchdog.
module taxi_mac_pause_ctrl_rx_mc #(
   parameter int CLASSES         = 8,
   parameter int MCF_PARAMS_SIZE = 18,
   parameter int QW              = 16,
   parameter int QFB             = 8,
   parameter int STEP_W          = 10,
   parameter int WDOG_W          = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mcf_valid,
   input  logic [47:0]                  mcf_eth_dst,
   input  logic [15:0]                  mcf_opcode,
   input  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
   input  logic                         rx_lfc_en,
   output logic                         rx_lfc_req,
   input  logic                         rx_lfc_ack,
   input  logic [CLASSES-1:0]           rx_pfc_en,
   output logic [CLASSES-1:0]           rx_pfc_req,
   input  logic [CLASSES-1:0]           rx_pfc_ack,
   input  logic [15:0]                  cfg_rx_lfc_opcode,
   input  logic                         cfg_rx_lfc_en,
   input  logic [15:0]                  cfg_rx_pfc_opcode,
   input  logic                         cfg_rx_pfc_en,
   input  logic                         cfg_dst_check_en,
   input  logic [STEP_W-1:0]            cfg_quanta_step,
   input  logic                         cfg_quanta_clk_en,
   input  logic [WDOG_W-1:0]            cfg_ack_timeout,
   output logic                         stat_rx_lfc_pkt,
   output logic                         stat_rx_pfc_pkt,
   output logic                         stat_rx_mcf_drop,
   output logic                         stat_rx_lfc_paused,
   output logic [CLASSES-1:0]           stat_rx_pfc_paused,
   output logic [CLASSES:0]             stat_rx_ack_timeout
);

   localparam int CH = CLASSES + 1;
   localparam int PW = QFB + 2;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REQ    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;

   localparam logic [47:0] MCF_DST = 48'h0180C2000001;

   generate
      if (CLASSES < 1 || CLASSES > 8) begin : g_bad_classes
         $fatal(1, "CLASSES must be 1..8");
      end
      if (MCF_PARAMS_SIZE < 2 + 2*CLASSES) begin : g_bad_size
         $fatal(1, "MCF_PARAMS_SIZE too small for CLASSES");
      end
      if (STEP_W > QFB + 2) begin : g_bad_step
         $fatal(1, "STEP_W must be <= QFB+2");
      end
   endgenerate

   // quanta prescaler: inc carries whole quanta out of the fractional count
   logic [QFB-1:0] pre_cnt;
   logic [1:0]     pre_inc;
   logic [PW-1:0]  pre_sum;

   assign pre_sum = {2'b00, pre_cnt} + PW'(cfg_quanta_step);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         pre_inc <= '0;
      end else if (cfg_quanta_clk_en) begin
         {pre_inc, pre_cnt} <= pre_sum;
      end else begin
         pre_inc <= '0;
      end
   end

   logic dst_ok;
   logic lfc_hit;
   logic pfc_hit;
   logic drop_hit;

   assign dst_ok   = !cfg_dst_check_en || (mcf_eth_dst == MCF_DST);
   assign lfc_hit  = mcf_valid && dst_ok && cfg_rx_lfc_en &&
                     (mcf_opcode == cfg_rx_lfc_opcode);
   assign pfc_hit  = mcf_valid && dst_ok && !lfc_hit && cfg_rx_pfc_en &&
                     (mcf_opcode == cfg_rx_pfc_opcode);
   assign drop_hit = mcf_valid && !lfc_hit && !pfc_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_rx_lfc_pkt  <= 1'b0;
         stat_rx_pfc_pkt  <= 1'b0;
         stat_rx_mcf_drop <= 1'b0;
      end else begin
         stat_rx_lfc_pkt  <= lfc_hit;
         stat_rx_pfc_pkt  <= pfc_hit;
         stat_rx_mcf_drop <= drop_hit;
      end
   end

   // channel CLASSES is the LFC channel, 0..CLASSES-1 are PFC classes
   logic [CH-1:0] ch_en;
   logic [CH-1:0] ch_ack;
   logic [CH-1:0] ch_upd;
   logic [15:0]   ch_q [CH];
   logic [CH-1:0] req_v;
   logic [CH-1:0] to_v;

   generate
      for (genvar k = 0; k < CLASSES; k++) begin : g_pfc_map
         assign ch_en[k]  = rx_pfc_en[k] & cfg_rx_pfc_en;
         assign ch_ack[k] = rx_pfc_ack[k];
         assign ch_upd[k] = pfc_hit & mcf_params[k+8];
         assign ch_q[k]   = {mcf_params[8*(2+2*k) +: 8],
                             mcf_params[8*(3+2*k) +: 8]};
      end
   endgenerate

   assign ch_en[CLASSES]  = rx_lfc_en & cfg_rx_lfc_en;
   assign ch_ack[CLASSES] = rx_lfc_ack;
   assign ch_upd[CLASSES] = lfc_hit;
   assign ch_q[CLASSES]   = {mcf_params[7:0], mcf_params[15:8]};

   generate
      for (genvar c = 0; c < CH; c++) begin : g_ch
         logic [1:0]        state;
         logic [1:0]        state_nx;
         logic [QW-1:0]     timer;
         logic [QW-1:0]     timer_nx;
         logic [QW-1:0]     dec;
         logic              req_q;
         logic [WDOG_W-1:0] wdog;
         logic              wd_pulse;

         assign dec = (timer > QW'(pre_inc)) ? timer - QW'(pre_inc) : '0;

         // a frame update wins over the decrement in the same cycle
         always_comb begin
            state_nx = state;
            timer_nx = timer;
            if (ch_upd[c]) begin
               if (ch_q[c] != 16'd0) begin
                  timer_nx = QW'(ch_q[c]);
                  if (state == ST_IDLE) begin
                     state_nx = ST_REQ;
                  end
               end else begin
                  timer_nx = '0;
                  state_nx = ST_IDLE;
               end
            end else begin
               unique case (1'b1)
                  (state == ST_REQ): begin
                     if (ch_ack[c]) begin
                        state_nx = ST_PAUSED;
                     end
                  end
                  (state == ST_PAUSED): begin
                     if (ch_ack[c]) begin
                        timer_nx = dec;
                        if (dec == '0) begin
                           state_nx = ST_IDLE;
                        end
                     end else if (timer != '0) begin
                        state_nx = ST_REQ;
                     end else begin
                        state_nx = ST_IDLE;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state <= ST_IDLE;
               timer <= '0;
               req_q <= 1'b0;
            end else begin
               state <= state_nx;
               timer <= timer_nx;
               req_q <= (state_nx != ST_IDLE) & ch_en[c];
            end
         end

         // watchdog saturates at the limit so the pulse fires only once
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wdog     <= '0;
               wd_pulse <= 1'b0;
            end else if (!req_q || ch_ack[c] || state == ST_IDLE) begin
               wdog     <= '0;
               wd_pulse <= 1'b0;
            end else if (cfg_ack_timeout != '0 && wdog < cfg_ack_timeout) begin
               wdog     <= wdog + WDOG_W'(1);
               wd_pulse <= (wdog + WDOG_W'(1)) == cfg_ack_timeout;
            end else begin
               wd_pulse <= 1'b0;
            end
         end

         assign req_v[c] = req_q;
         assign to_v[c]  = wd_pulse;
      end
   endgenerate

   assign rx_pfc_req          = req_v[CLASSES-1:0];
   assign rx_lfc_req          = req_v[CLASSES];
   assign stat_rx_pfc_paused  = req_v[CLASSES-1:0];
   assign stat_rx_lfc_paused  = req_v[CLASSES];
   assign stat_rx_ack_timeout = to_v;

endmodule

// File: tb/tb_taxi_mac_pause_ctrl_rx_mc.sv
// Directed bench for taxi_mac_pause_ctrl_rx_mc: frame decode table plus
// multi-cycle pause, refresh, reset and watchdog sequences.
module tb_taxi_mac_pause_ctrl_rx_mc;

   localparam logic [47:0] D_OK  = 48'h0180C2000001;
   localparam logic [47:0] D_BAD = 48'h0180C2000002;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         mcf_valid;
   logic [47:0]  mcf_eth_dst;
   logic [15:0]  mcf_opcode;
   logic [143:0] mcf_params;
   logic         rx_lfc_en;
   logic         rx_lfc_req;
   logic         rx_lfc_ack;
   logic [7:0]   rx_pfc_en;
   logic [7:0]   rx_pfc_req;
   logic [7:0]   rx_pfc_ack;
   logic [15:0]  cfg_rx_lfc_opcode;
   logic         cfg_rx_lfc_en;
   logic [15:0]  cfg_rx_pfc_opcode;
   logic         cfg_rx_pfc_en;
   logic         cfg_dst_check_en;
   logic [9:0]   cfg_quanta_step;
   logic         cfg_quanta_clk_en;
   logic [15:0]  cfg_ack_timeout;
   logic         stat_rx_lfc_pkt;
   logic         stat_rx_pfc_pkt;
   logic         stat_rx_mcf_drop;
   logic         stat_rx_lfc_paused;
   logic [7:0]   stat_rx_pfc_paused;
   logic [8:0]   stat_rx_ack_timeout;

   logic ack_l;
   logic ack_p;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // TX side acknowledges immediately while enabled
   assign rx_lfc_ack = ack_l & rx_lfc_req;
   assign rx_pfc_ack = {8{ack_p}} & rx_pfc_req;

   taxi_mac_pause_ctrl_rx_mc dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .mcf_valid           (mcf_valid),
      .mcf_eth_dst         (mcf_eth_dst),
      .mcf_opcode          (mcf_opcode),
      .mcf_params          (mcf_params),
      .rx_lfc_en           (rx_lfc_en),
      .rx_lfc_req          (rx_lfc_req),
      .rx_lfc_ack          (rx_lfc_ack),
      .rx_pfc_en           (rx_pfc_en),
      .rx_pfc_req          (rx_pfc_req),
      .rx_pfc_ack          (rx_pfc_ack),
      .cfg_rx_lfc_opcode   (cfg_rx_lfc_opcode),
      .cfg_rx_lfc_en       (cfg_rx_lfc_en),
      .cfg_rx_pfc_opcode   (cfg_rx_pfc_opcode),
      .cfg_rx_pfc_en       (cfg_rx_pfc_en),
      .cfg_dst_check_en    (cfg_dst_check_en),
      .cfg_quanta_step     (cfg_quanta_step),
      .cfg_quanta_clk_en   (cfg_quanta_clk_en),
      .cfg_ack_timeout     (cfg_ack_timeout),
      .stat_rx_lfc_pkt     (stat_rx_lfc_pkt),
      .stat_rx_pfc_pkt     (stat_rx_pfc_pkt),
      .stat_rx_mcf_drop    (stat_rx_mcf_drop),
      .stat_rx_lfc_paused  (stat_rx_lfc_paused),
      .stat_rx_pfc_paused  (stat_rx_pfc_paused),
      .stat_rx_ack_timeout (stat_rx_ack_timeout)
   );

   typedef struct {
      logic [15:0]      op;
      logic [47:0]      dst;
      logic             chk;
      logic [15:0]      lq;
      logic [7:0]       ev;
      logic [7:0][15:0] pq;
      logic             e_lfc;
      logic             e_pfc;
      logic             e_drop;
      logic             e_lreq;
      logic [7:0]       e_preq;
   } vec_t;

   vec_t tv [10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [143:0] mkp(input logic [15:0] lq,
                                        input logic [7:0] ev,
                                        input logic [7:0][15:0] pq);
      logic [143:0] p;
      p = '0;
      p[7:0]  = lq[15:8];
      p[15:8] = lq[7:0] | ev;
      for (int k = 0; k < 8; k++) begin
         p[8*(2+2*k) +: 8] = pq[k][15:8];
         p[8*(3+2*k) +: 8] = pq[k][7:0];
      end
      return p;
   endfunction

   task automatic setv(input int i, input logic [15:0] op,
                       input logic [47:0] dst, input logic c,
                       input logic [15:0] lq, input logic [7:0] ev,
                       input logic el, input logic ep, input logic ed,
                       input logic elr, input logic [7:0] epr);
      tv[i].op     = op;
      tv[i].dst    = dst;
      tv[i].chk    = c;
      tv[i].lq     = lq;
      tv[i].ev     = ev;
      tv[i].pq     = '0;
      tv[i].e_lfc  = el;
      tv[i].e_pfc  = ep;
      tv[i].e_drop = ed;
      tv[i].e_lreq = elr;
      tv[i].e_preq = epr;
   endtask

   // frame strobed on one edge; returns 1 ns after that edge
   task automatic send(input logic [15:0] op, input logic [47:0] dst,
                       input logic [143:0] p);
      @(negedge clk);
      mcf_valid   = 1'b1;
      mcf_opcode  = op;
      mcf_eth_dst = dst;
      mcf_params  = p;
      @(posedge clk);
      #1;
      mcf_valid = 1'b0;
   endtask

   // counts the current sample plus following cycles with req high
   task automatic count_lfc(output int cnt);
      cnt = rx_lfc_req ? 1 : 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (!rx_lfc_req) break;
         cnt++;
      end
   endtask

   initial begin
      logic [7:0][15:0] pq;
      int cnt;
      int pulses;
      int first;

      rst_n             = 1'b0;
      mcf_valid         = 1'b0;
      mcf_eth_dst       = '0;
      mcf_opcode        = '0;
      mcf_params        = '0;
      rx_lfc_en         = 1'b1;
      rx_pfc_en         = 8'hFF;
      cfg_rx_lfc_opcode = 16'h0001;
      cfg_rx_lfc_en     = 1'b1;
      cfg_rx_pfc_opcode = 16'h0101;
      cfg_rx_pfc_en     = 1'b1;
      cfg_dst_check_en  = 1'b1;
      cfg_quanta_step   = 10'd256;
      cfg_quanta_clk_en = 1'b1;
      cfg_ack_timeout   = '0;
      ack_l             = 1'b0;
      ack_p             = 1'b0;

      setv(0, 16'h0001, D_OK,  1, 16'h0005, 8'h00, 1, 0, 0, 1, 8'h00);
      setv(1, 16'h0001, D_OK,  1, 16'h0000, 8'h00, 1, 0, 0, 0, 8'h00);
      setv(2, 16'h0101, D_OK,  1, 16'h0000, 8'h05, 0, 1, 0, 0, 8'h05);
      tv[2].pq[0] = 16'h0003;
      tv[2].pq[1] = 16'h0009;
      tv[2].pq[2] = 16'h0007;
      setv(3, 16'h0101, D_BAD, 0, 16'h0000, 8'h04, 0, 1, 0, 0, 8'h01);
      setv(4, 16'h0001, D_BAD, 1, 16'h0005, 8'h00, 0, 0, 1, 0, 8'h01);
      setv(5, 16'h0001, D_BAD, 0, 16'h0005, 8'h00, 1, 0, 0, 1, 8'h01);
      setv(6, 16'h0002, D_OK,  0, 16'h0000, 8'h00, 0, 0, 1, 1, 8'h01);
      setv(7, 16'h0101, D_OK,  1, 16'h0000, 8'h80, 0, 1, 0, 1, 8'h81);
      tv[7].pq[7] = 16'h0020;
      setv(8, 16'h0101, D_OK,  1, 16'h0000, 8'hFF, 0, 1, 0, 1, 8'h00);
      setv(9, 16'h0001, D_OK,  1, 16'h0000, 8'h00, 1, 0, 0, 0, 8'h00);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_lfc_req", rx_lfc_req, 0);
      chk("rst_pfc_req", rx_pfc_req, 0);
      chk("rst_stats", {stat_rx_lfc_pkt, stat_rx_pfc_pkt, stat_rx_mcf_drop,
                        stat_rx_ack_timeout}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cfg_dst_check_en = tv[i].chk;
         send(tv[i].op, tv[i].dst, mkp(tv[i].lq, tv[i].ev, tv[i].pq));
         chk($sformatf("v%0d_lfc_pkt", i), stat_rx_lfc_pkt, tv[i].e_lfc);
         chk($sformatf("v%0d_pfc_pkt", i), stat_rx_pfc_pkt, tv[i].e_pfc);
         chk($sformatf("v%0d_drop", i), stat_rx_mcf_drop, tv[i].e_drop);
         chk($sformatf("v%0d_lfc_req", i), rx_lfc_req, tv[i].e_lreq);
         chk($sformatf("v%0d_pfc_req", i), rx_pfc_req, tv[i].e_preq);
      end
      @(posedge clk);
      #1;
      chk("stat_one_cycle", {stat_rx_lfc_pkt, stat_rx_pfc_pkt,
                             stat_rx_mcf_drop}, 0);
      cfg_dst_check_en = 1'b1;

      // LFC match wins when both opcodes are equal
      cfg_rx_pfc_opcode = 16'h0001;
      send(16'h0001, D_OK, mkp(16'h0004, 8'h00, '0));
      chk("prio_lfc_pkt", stat_rx_lfc_pkt, 1);
      chk("prio_pfc_pkt", stat_rx_pfc_pkt, 0);
      chk("prio_pfc_req", rx_pfc_req, 8'h00);
      cfg_rx_pfc_opcode = 16'h0101;
      send(16'h0001, D_OK, mkp(16'h0000, 8'h00, '0));
      chk("prio_xon", rx_lfc_req, 0);
      cfg_rx_lfc_en = 1'b0;
      send(16'h0001, D_OK, mkp(16'h0005, 8'h00, '0));
      chk("lfc_off_drop", stat_rx_mcf_drop, 1);
      chk("lfc_off_req", rx_lfc_req, 0);
      cfg_rx_lfc_en = 1'b1;

      // asynchronous reset in the middle of a pause
      ack_l = 1'b1;
      send(16'h0001, D_OK, mkp(16'h0040, 8'h00, '0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      chk("pre_rst_req", rx_lfc_req, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_req", rx_lfc_req, 0);
      chk("async_rst_paused", stat_rx_lfc_paused, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", rx_lfc_req, 0);

      // XOFF 10 quanta: one REQ cycle then ten decrements
      send(16'h0001, D_OK, mkp(16'h000A, 8'h00, '0));
      chk("xoff_lfc_pkt", stat_rx_lfc_pkt, 1);
      chk("xoff_paused", stat_rx_lfc_paused, 1);
      count_lfc(cnt);
      chk("xoff_req_cycles", cnt, 11);

      // refresh after four acked quanta overrides the decrement
      send(16'h0001, D_OK, mkp(16'h0010, 8'h00, '0));
      repeat (5) @(posedge clk);
      send(16'h0001, D_OK, mkp(16'h0008, 8'h00, '0));
      count_lfc(cnt);
      chk("refresh_cycles", cnt, 8);
      send(16'h0001, D_OK, mkp(16'h0020, 8'h00, '0));
      repeat (3) @(posedge clk);
      send(16'h0001, D_OK, mkp(16'h0000, 8'h00, '0));
      chk("xon_pkt", stat_rx_lfc_pkt, 1);
      chk("xon_req_low", rx_lfc_req, 0);

      // PFC partial update while class 2 is paused
      ack_p = 1'b1;
      pq = '0;
      pq[1] = 16'h0040;
      pq[2] = 16'h0040;
      send(16'h0101, D_OK, mkp(16'h0000, 8'h06, pq));
      repeat (3) @(posedge clk);
      #1;
      chk("pfc_setup", rx_pfc_req, 8'h06);
      pq = '0;
      pq[0] = 16'h0003;
      pq[1] = 16'h0001;
      send(16'h0101, D_OK, mkp(16'h0000, 8'h05, pq));
      chk("pfc_partial", rx_pfc_req, 8'h03);
      chk("pfc_partial_stat", stat_rx_pfc_paused, 8'h03);
      repeat (10) @(posedge clk);
      #1;
      chk("pfc_class0_done", rx_pfc_req, 8'h02);
      pq = '0;
      send(16'h0101, D_OK, mkp(16'h0000, 8'h02, pq));
      chk("pfc_class1_xon", rx_pfc_req, 8'h00);

      // watchdog with ack held low
      ack_l = 1'b0;
      ack_p = 1'b0;
      cfg_ack_timeout = 16'd5;
      send(16'h0001, D_OK, mkp(16'h000A, 8'h00, '0));
      pulses = 0;
      first  = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (stat_rx_ack_timeout[8]) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      chk("wdog_pulses", pulses, 1);
      chk("wdog_cycle", first, 5);
      chk("wdog_req_held", rx_lfc_req, 1);
      chk("wdog_pfc_quiet", stat_rx_ack_timeout[7:0], 0);
      @(negedge clk);
      ack_l = 1'b1;
      @(posedge clk);
      #1;
      count_lfc(cnt);
      chk("wdog_timer_frozen", cnt, 10);
      cfg_ack_timeout = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

endmodule
